// File: rtl/norm_phase_seq.sv
// norm_phase_seq: round-robin green sequencer for the 4-approach intersection in NORMAL mode.
// Demand-skipping green phases separated by all-red clearance, gated by operate and timer enables.
`default_nettype none

module norm_phase_seq #(
  parameter int GREEN_CYCLES = 8,
  parameter int CLEAR_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cnt_en,
  input  logic       demand_0,
  input  logic       demand_1,
  input  logic       demand_2,
  input  logic       demand_3,
  output logic       allow_0_norm,
  output logic       allow_1_norm,
  output logic       allow_2_norm,
  output logic       allow_3_norm,
  output logic [1:0] phase,
  output logic       phase_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GREEN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       phase_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;

  logic [3:0]       demand;
  logic             other_demand;
  logic [1:0]       pick;
  logic [1:0]       cand;
  logic             found;

  assign demand       = {demand_3, demand_2, demand_1, demand_0};
  assign other_demand = |(demand & ~(4'b0001 << phase));

  // Search the other approaches in rotation order starting just after the current one.
  always_comb begin
    pick  = phase;
    cand  = phase;
    found = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cand = phase + 2'(k);
      if (!found && demand[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (!en) begin
      // Losing the operate enable beats any timer expiry in the same cycle.
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = GREEN;
          cnt_nxt   = '0;
        end
        GREEN: begin
          if (cnt_en) begin
            if (cnt == GREEN_LAST) begin
              cnt_nxt = '0;
              if (other_demand) begin
                state_nxt = CLEAR;
                done_nxt  = 1'b1;
              end
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        CLEAR: begin
          if (cnt_en) begin
            if (cnt == CLEAR_LAST) begin
              state_nxt = GREEN;
              cnt_nxt   = '0;
              phase_nxt = pick;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 2'd0;
      cnt        <= '0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      cnt        <= cnt_nxt;
      phase_done <= done_nxt;
    end
  end

  assign allow_0_norm = (state == GREEN) && (phase == 2'd0);
  assign allow_1_norm = (state == GREEN) && (phase == 2'd1);
  assign allow_2_norm = (state == GREEN) && (phase == 2'd2);
  assign allow_3_norm = (state == GREEN) && (phase == 2'd3);

endmodule

`default_nettype wire

// File: doc/norm_phase_seq.md
Name: norm_phase_seq

Overview:
- Normal-mode signal sequencer for the 4-approach intersection.
- Generates the allow_x_norm grants that the control unit forwards to the lights when it is in NORMAL state.
- Gated by the control unit's norm_opp_en (operate) and norm_counter_en (timer advance).
- Runs round-robin green phases separated by all-red clearance, and skips approaches with no waiting demand.

Parameters:
GREEN_CYCLES, 8, green duration per phase in counted cycles (>=1)
CLEAR_CYCLES, 2, all-red clearance duration in counted cycles (>=1)
CNT_W, 8, phase timer width; must hold max(GREEN_CYCLES, CLEAR_CYCLES)-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  operate enable (from norm_opp_en)
cnt_en  in  1  timer advance enable (from norm_counter_en)
demand_0  in  1  vehicle waiting on approach 0
demand_1  in  1  vehicle waiting on approach 1
demand_2  in  1  vehicle waiting on approach 2
demand_3  in  1  vehicle waiting on approach 3
allow_0_norm  out  1  green grant approach 0
allow_1_norm  out  1  green grant approach 1
allow_2_norm  out  1  green grant approach 2
allow_3_norm  out  1  green grant approach 3
phase  out  2  index of current/last green approach
phase_done  out  1  one-cycle pulse when a green phase ends

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, phase=0, cnt=0, phase_done=0. All allow_x_norm=0. Reset overrides en and cnt_en and takes effect mid-phase.
- Registers: state (IDLE/GREEN/CLEAR), phase[1:0], cnt[CNT_W-1:0], phase_done.
- allow_x_norm are decoded from registered state/phase only (Moore). allow_x_norm = (state==GREEN && phase==x).
- At most one allow is high in any cycle.
- IDLE:
  - Outputs all 0, cnt held at 0.
  - en=1 -> GREEN next cycle, phase unchanged, cnt=0.
  - Demand is ignored on entry: the stored phase always gets a green first.
- GREEN:
  - cnt_en=1 and cnt<GREEN_CYCLES-1 -> cnt+1.
  - cnt_en=0 -> cnt holds. The green is frozen, not terminated.
  - cnt_en=1 and cnt==GREEN_CYCLES-1:
    - If any demand_y=1 with y!=phase -> CLEAR, cnt=0, phase_done=1 for exactly that next cycle.
    - Else extend: stay GREEN, cnt=0, no pulse.
- CLEAR:
  - All allow 0. cnt advances under cnt_en exactly as in GREEN.
  - cnt_en=1 and cnt==CLEAR_CYCLES-1 -> GREEN, cnt=0.
  - New phase = first y in order phase+1, phase+2, phase+3 (mod 4) with demand_y=1, sampled in that cycle.
  - If none are demanding, phase is unchanged.
- en=0 in GREEN or CLEAR:
  - Next cycle state=IDLE, cnt=0, phase retained.
  - Any active green drops one cycle after en falls.
  - A pending phase_done pulse is still emitted if already scheduled.
- Re-enable after abort restarts a full green on the retained phase. In particular, CLEAR aborted by en=0 resumes the old phase and does not advance.
- en has priority over cnt_en. The en=0 transition wins over simultaneous timer expiry.
- phase_done is registered, 0 in all other cycles.
- Counter never exceeds its terminal value. No wrap beyond GREEN_CYCLES-1 or CLEAR_CYCLES-1.
- Latency: en rise -> allow high at next posedge (1 cycle).

Test Plan:
- GREEN=4, CLEAR=2, all demand=1, cnt_en=1, en rises:
  - allow_0 high 4 cycles, then all-0 for 2 cycles, then allow_1 high 4 cycles; phase_done pulses once on the first CLEAR cycle.
  - Sequence continues 0->1->2->3->0.
- Only demand_2=1, phase=0:
  - After green 0 plus 2 clear cycles, allow_2 is granted (1 and 3 skipped).
  - With demand_2 also 0, allow_0 stays high continuously with no phase_done pulses.
- cnt_en held low 3 cycles mid-GREEN:
  - Green lengthens by exactly 3 cycles; cnt value is frozen throughout.
- en dropped at cnt=2 of GREEN phase 1:
  - allow_1 falls one cycle later, state IDLE.
  - en re-raised: allow_1 high for a full 4 counted cycles.
- en dropped during CLEAR after phase 1, then restored:
  - Green returns to phase 1, not 2.
- rst asserted mid-GREEN phase 3:
  - Next cycle all allows=0, phase=0, phase_done=0.
  - With rst low and en=1, allow_0 rises one cycle later.
